// File: rtl/cond_pkg.sv
// Shared types and the ARM condition-code evaluator for the multi-lane
// conditional-execution unit.
package cond_pkg;

  typedef logic [3:0] flags_t;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // The 1111 encoding is treated as never-execute.
  function automatic logic cond_pass(input cond_e cond, input flags_t flags);
    logic n;
    logic z;
    logic c;
    logic v;
    logic pass;
    n = flags[N_BIT];
    z = flags[Z_BIT];
    c = flags[C_BIT];
    v = flags[V_BIT];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/cond_lane.sv
// One combinational lane of the in-order condition chain: evaluates its
// condition on forwarded flags, applies its flag writes and propagates annulment.
module cond_lane
  import cond_pkg::*;
(
  input  logic       valid,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       redirect,
  input  logic [3:0] flags_in,
  input  logic       kill_in,
  output logic       ex,
  output logic [3:0] flags_out,
  output logic       kill_out
);

  // Condition evaluation, partial flag update and kill propagation.
  always_comb begin
    ex        = valid & cond_pass(cond_e'(cond), flags_in) & ~kill_in;
    flags_out = flags_in;
    if (ex && flag_w[1]) begin
      flags_out[N_BIT] = alu_flags[N_BIT];
      flags_out[Z_BIT] = alu_flags[Z_BIT];
    end else begin
      flags_out[N_BIT] = flags_in[N_BIT];
      flags_out[Z_BIT] = flags_in[Z_BIT];
    end
    if (ex && flag_w[0]) begin
      flags_out[C_BIT] = alu_flags[C_BIT];
      flags_out[V_BIT] = alu_flags[V_BIT];
    end else begin
      flags_out[C_BIT] = flags_in[C_BIT];
      flags_out[V_BIT] = flags_in[V_BIT];
    end
    kill_out = kill_in | (ex & redirect);
  end

endmodule

// File: rtl/cond_unit_multi.sv
// Multi-lane conditional-execution unit: NZCV register, in-order lane chain
// and registered write enables. COND_PERF_CNT_EN adds execute/annul counters.
module cond_unit_multi
  import cond_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = 32,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0]   valid_i,
  input  logic [4*LANES-1:0] cond_i,
  input  logic [4*LANES-1:0] alu_flags_i,
  input  logic [2*LANES-1:0] flag_w_i,
  input  logic [LANES-1:0]   pcs_i,
  input  logic [LANES-1:0]   regw_i,
  input  logic [LANES-1:0]   memw_i,
  input  logic [LANES-1:0]   branch_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [3:0]         flags_o,
  output logic [LANES-1:0]   reg_write_o,
  output logic [LANES-1:0]   mem_write_o,
  output logic             pc_src_o,
  output logic [LW-1:0]      pc_src_lane_o,
`ifdef COND_PERF_CNT_EN
  output logic [CNT_W-1:0]   exec_cnt_o,
  output logic [CNT_W-1:0]   annul_cnt_o,
`endif
  output logic [LANES-1:0]   cond_ex_o
);

  flags_t           flags_r;
  flags_t           flags_final_s;
  logic [LANES-1:0] ex_s;
  logic [LANES-1:0] redirect_s;
  logic             pc_src_s;
  logic [LW-1:0]    pc_lane_s;
  logic [LANES-1:0] reg_write_r;
  logic [LANES-1:0] mem_write_r;
  logic [LANES-1:0] cond_ex_r;
  logic             pc_src_r;
  logic [LW-1:0]    pc_lane_r;
  logic             hold_s;

  assign redirect_s = pcs_i | branch_i;
  assign hold_s     = stall_i | flush_i;

  // Lane i reads the flags and kill produced by lane i-1 in the same cycle.
  for (genvar i = 0; i < LANES; i++) begin : lane_g
    logic [3:0] flags_in_s;
    logic [3:0] flags_next_s;
    logic       kill_in_s;
    logic       kill_next_s;
    logic       ex_lane_s;

    if (i == 0) begin : first_g
      assign flags_in_s = flags_r;
      assign kill_in_s  = 1'b0;
    end else begin : rest_g
      assign flags_in_s = lane_g[i-1].flags_next_s;
      assign kill_in_s  = lane_g[i-1].kill_next_s;
    end

    cond_lane u_lane (
      .valid     (valid_i[i]),
      .cond      (cond_i[4*i +: 4]),
      .alu_flags (alu_flags_i[4*i +: 4]),
      .flag_w    (flag_w_i[2*i +: 2]),
      .redirect  (redirect_s[i]),
      .flags_in  (flags_in_s),
      .kill_in   (kill_in_s),
      .ex        (ex_lane_s),
      .flags_out (flags_next_s),
      .kill_out  (kill_next_s)
    );

    assign ex_s[i] = ex_lane_s;
  end

  assign flags_final_s = lane_g[LANES-1].flags_next_s;

  // Oldest redirecting lane wins; annulment means at most one can fire anyway.
  always_comb begin
    pc_src_s  = 1'b0;
    pc_lane_s = {LW{1'b0}};
    for (int i = LANES - 1; i >= 0; i--) begin
      if (ex_s[i] && redirect_s[i]) begin
        pc_src_s  = 1'b1;
        pc_lane_s = LW'(i);
      end else begin
        pc_src_s  = pc_src_s;
        pc_lane_s = pc_lane_s;
      end
    end
  end

  // Flags register and output stage; stall or flush inserts a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r     <= 4'b0000;
      reg_write_r <= {LANES{1'b0}};
      mem_write_r <= {LANES{1'b0}};
      cond_ex_r   <= {LANES{1'b0}};
      pc_src_r    <= 1'b0;
      pc_lane_r   <= {LW{1'b0}};
    end else if (hold_s) begin
      flags_r     <= flags_r;
      reg_write_r <= {LANES{1'b0}};
      mem_write_r <= {LANES{1'b0}};
      cond_ex_r   <= {LANES{1'b0}};
      pc_src_r    <= 1'b0;
      pc_lane_r   <= {LW{1'b0}};
    end else begin
      flags_r     <= flags_final_s;
      reg_write_r <= regw_i & ex_s;
      mem_write_r <= memw_i & ex_s;
      cond_ex_r   <= ex_s;
      pc_src_r    <= pc_src_s;
      pc_lane_r   <= pc_lane_s;
    end
  end

  assign flags_o       = flags_r;
  assign reg_write_o   = reg_write_r;
  assign mem_write_o   = mem_write_r;
  assign cond_ex_o     = cond_ex_r;
  assign pc_src_o      = pc_src_r;
  assign pc_src_lane_o = pc_lane_r;

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_cnt_r;
  logic [CNT_W-1:0] annul_cnt_r;
  logic [CNT_W-1:0] exec_inc_s;
  logic [CNT_W-1:0] annul_inc_s;

  // Popcounts of executed and annulled/failed valid lanes this cycle.
  always_comb begin
    exec_inc_s  = {CNT_W{1'b0}};
    annul_inc_s = {CNT_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      exec_inc_s  = exec_inc_s + CNT_W'(ex_s[i]);
      annul_inc_s = annul_inc_s + CNT_W'(valid_i[i] & ~ex_s[i]);
    end
  end

  // Counters wrap naturally at CNT_W bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_cnt_r  <= {CNT_W{1'b0}};
      annul_cnt_r <= {CNT_W{1'b0}};
    end else if (hold_s) begin
      exec_cnt_r  <= exec_cnt_r;
      annul_cnt_r <= annul_cnt_r;
    end else begin
      exec_cnt_r  <= exec_cnt_r + exec_inc_s;
      annul_cnt_r <= annul_cnt_r + annul_inc_s;
    end
  end

  assign exec_cnt_o  = exec_cnt_r;
  assign annul_cnt_o = annul_cnt_r;
`endif

endmodule

// File: tb/tb_cond_unit_multi.sv
// Directed self-checking bench for cond_unit_multi with two lanes;
// counter checks are compiled in when COND_PERF_CNT_EN is defined.
module tb_cond_unit_multi;
  localparam int LANES = 2;
  localparam int LW = 1;
`ifdef COND_PERF_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif

  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] LS = 4'b1001;
  localparam logic [3:0] GE = 4'b1010;
  localparam logic [3:0] LT = 4'b1011;
  localparam logic [3:0] GT = 4'b1100;
  localparam logic [3:0] AL = 4'b1110;
  localparam logic [3:0] NV = 4'b1111;

  logic clk = 1'b0;
  logic reset;
  logic [LANES-1:0]   valid_i;
  logic [4*LANES-1:0] cond_i;
  logic [4*LANES-1:0] alu_flags_i;
  logic [2*LANES-1:0] flag_w_i;
  logic [LANES-1:0]   pcs_i, regw_i, memw_i, branch_i;
  logic stall_i, flush_i;
  logic [3:0]         flags_o;
  logic [LANES-1:0]   reg_write_o, mem_write_o, cond_ex_o;
  logic               pc_src_o;
  logic [LW-1:0]      pc_src_lane_o;
`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0]   exec_cnt_o, annul_cnt_o;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cond_unit_multi #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_i),
    .cond_i        (cond_i),
    .alu_flags_i   (alu_flags_i),
    .flag_w_i      (flag_w_i),
    .pcs_i         (pcs_i),
    .regw_i        (regw_i),
    .memw_i        (memw_i),
    .branch_i      (branch_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .flags_o       (flags_o),
    .reg_write_o   (reg_write_o),
    .mem_write_o   (mem_write_o),
    .pc_src_o      (pc_src_o),
    .pc_src_lane_o (pc_src_lane_o),
`ifdef COND_PERF_CNT_EN
    .exec_cnt_o    (exec_cnt_o),
    .annul_cnt_o   (annul_cnt_o),
`endif
    .cond_ex_o     (cond_ex_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] fl, input logic [1:0] rw,
                           input logic [1:0] mw, input logic ps, input logic pl,
                           input logic [1:0] cx);
    check({tag, ".flags"}, 32'(flags_o), 32'(fl));
    check({tag, ".reg_write"}, 32'(reg_write_o), 32'(rw));
    check({tag, ".mem_write"}, 32'(mem_write_o), 32'(mw));
    check({tag, ".pc_src"}, 32'(pc_src_o), 32'(ps));
    check({tag, ".pc_lane"}, 32'(pc_src_lane_o), 32'(pl));
    check({tag, ".cond_ex"}, 32'(cond_ex_o), 32'(cx));
  endtask

  task automatic clear_inputs();
    valid_i = '0; cond_i = '0; alu_flags_i = '0; flag_w_i = '0;
    pcs_i = '0; regw_i = '0; memw_i = '0; branch_i = '0;
  endtask

  task automatic set_lane(input int l, input logic [3:0] cond, input logic [3:0] alu,
                          input logic [1:0] fw, input logic pcs, input logic regw,
                          input logic memw, input logic br);
    valid_i[l] = 1'b1;
    cond_i[4*l +: 4] = cond;
    alu_flags_i[4*l +: 4] = alu;
    flag_w_i[2*l +: 2] = fw;
    pcs_i[l] = pcs;
    regw_i[l] = regw;
    memw_i[l] = memw;
    branch_i[l] = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    clear_inputs();
    step();
    check_out("reset", 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    @(negedge clk) reset = 1'b0;

    // CMP sets Z; BEQ in lane 1 sees it via forwarding
    clear_inputs();
    set_lane(0, AL, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    set_lane(1, EQ, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check_out("cmp_beq", 4'b0100, 2'b01, 2'b00, 1'b1, 1'b1, 2'b11);

    clear_inputs();
    set_lane(0, AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    set_lane(1, AL, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("br_annul", 4'b0100, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01);

    clear_inputs();
    set_lane(0, AL, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("set_n", 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01);

    clear_inputs();
    set_lane(0, GE, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    set_lane(1, LT, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("ge_lt", 4'b1000, 2'b10, 2'b00, 1'b0, 1'b0, 2'b10);

    clear_inputs();
    set_lane(0, AL, 4'b0001, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    stall_i = 1'b1;
    step();
    check_out("stall", 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    flush_i = 1'b1;
    step();
    check_out("stall_flush", 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    stall_i = 1'b0;
    step();
    check_out("flush", 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    flush_i = 1'b0;
    step();
    check_out("replay", 4'b0001, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01);

    // NZ-only write from a branching lane; younger flag write is annulled
    clear_inputs();
    set_lane(0, AL, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
    set_lane(1, AL, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("part_annul", 4'b1001, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01);

    clear_inputs();
    set_lane(0, NV, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    set_lane(1, GT, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_out("nv_gt", 4'b1001, 2'b00, 2'b10, 1'b0, 1'b0, 2'b10);

    clear_inputs();
    set_lane(0, AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    valid_i[0] = 1'b0;
    set_lane(1, AL, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("inv_br", 4'b1001, 2'b10, 2'b00, 1'b0, 1'b0, 2'b10);

    clear_inputs();
    set_lane(0, LS, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    set_lane(1, AL, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_out("ls_pcs", 4'b1001, 2'b01, 2'b00, 1'b1, 1'b1, 2'b11);

    clear_inputs();
    set_lane(0, AL, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("set_all", 4'b1111, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01);
    #1 reset = 1'b1;
    #1;
    check_out("async_rst", 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    @(negedge clk) reset = 1'b0;
    clear_inputs();
    set_lane(0, AL, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("post_rst", 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01);

`ifdef COND_PERF_CNT_EN
    #1 reset = 1'b1;
    #1;
    check("cnt_rst.exec", 32'(exec_cnt_o), 32'd0);
    check("cnt_rst.annul", 32'(annul_cnt_o), 32'd0);
    @(negedge clk) reset = 1'b0;
    clear_inputs();
    set_lane(0, AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    set_lane(1, AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) step();
    check("cnt_wrap.exec", 32'(exec_cnt_o), 32'd2);
    check("cnt_wrap.annul", 32'(annul_cnt_o), 32'd0);
    cond_i[3:0] = NV;
    step();
    check("cnt_nv.exec", 32'(exec_cnt_o), 32'd3);
    check("cnt_nv.annul", 32'(annul_cnt_o), 32'd1);
    stall_i = 1'b1;
    step();
    check("cnt_stall.exec", 32'(exec_cnt_o), 32'd3);
    stall_i = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
